bin2bcd_seq: RTL
================

// Module: bin2bcd_seq
// PURPOSE
//  Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//  The adder blocks take BCD/binary operands and produce a binary sum. This
//  block converts that binary result back into BCD digits for the HEX display
//  path on the DE10-Lite top level.
//  It uses a start/busy/done handshake, so a single instance can be shared by
//  several result sources.
// PARAMETERS
//  BIN_W   8  width of the binary input; also the conversion length in cycles
//  DIGITS  3  number of BCD output digits (4 bits each)
// PORTS
//  clk      in   1            system clock (MAX10_CLK1_50 at top); rising edge
//  rst_n    in   1            asynchronous reset, active-low
//  start    in   1            request a conversion; sampled only in IDLE
//  bin      in   BIN_W        binary value; captured on the accepted start cycle
//  busy     out  1            high while a conversion is in progress
//  done     out  1            one-cycle pulse when bcd/ovf are updated
//  bcd      out  4*DIGITS     result; digit k in bits [4k+3:4k], k=0 is units
//  ovf      out  1            result exceeded 10^DIGITS-1; valid with done
//  seg      out  8*DIGITS     only when BIN2BCD_SEG7_EN is defined (see below)
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, busy=0, done=0, bcd=0,
//    ovf=0, shift/scratch registers=0, bit counter=0, seg=all ones.
//  - FSM IDLE -> SHIFT -> FINISH -> IDLE.
//  - IDLE: start=1 -> latch bin into shift reg, clear scratch and ovf_acc,
//    set counter=BIN_W, go to SHIFT. busy rises on the next edge.
//  - SHIFT, once per cycle:
//    - every scratch digit >=5 gets +3 (4-bit add, no carry into neighbour);
//    - then {scratch, shift} shift left by 1 as one register;
//    - a 1 shifted out of the top digit sets ovf_acc (sticky);
//    - counter decrements; at counter==1 go to FINISH.
//  - FINISH: bcd<=scratch, ovf<=ovf_acc, done=1 for this cycle only,
//    busy=0, go to IDLE.
//  - Latency: start accepted at edge N -> done high after edge N+BIN_W+1.
//    A new start is accepted in the cycle after done.
//  - start while busy (SHIFT/FINISH) is ignored. bin is not re-sampled.
//  - bcd/ovf hold their previous values until the next FINISH. They never
//    show partial results.
//  - When no overflow occurs, every output digit is 0..9.
//  - bin=0 still takes the full BIN_W+1 cycles.
//  - Reset mid-conversion aborts it: no done pulse, all outputs return to
//    reset values.
//  - Scratch width is 4*DIGITS. For ovf to be meaningful,
//    DIGITS < ceil(BIN_W*log10(2)).
// CONFIGURATION
//  - BIN2BCD_SEG7_EN defined: port seg is present.
//    - seg[8k+7:8k] is the active-low 7-seg code of bcd digit k.
//    - Bit order is {dp,g,f,e,d,c,b,a}; dp is always 1 (off).
//    - Codes 0..9: C0,F9,A4,B0,99,92,82,F8,80,90.
//    - seg is registered and updates in the same cycle as bcd.
//    - If ovf=1, all digits show '-' (8'hBF). Reset value is all 8'hFF.
//  - Not defined: seg port and decode logic are absent; all else is identical.
// TESTING
//  1. Reset, then start with bin=8'd0 -> done after 9 edges, bcd=12'h000,
//     ovf=0.
//  2. bin=8'd255 -> bcd=12'h255, ovf=0; busy high for exactly 8 cycles.
//  3. bin=8'd99, then start=1 held for the whole conversion with bin changed
//     to 8'd7 -> exactly one done, bcd=12'h099; a second done follows with
//     bcd=12'h007.
//  4. Assert rst_n=0 mid-conversion (after 4 SHIFT cycles) -> busy=0, bcd=0,
//     no done pulse; next start with bin=8'd42 -> bcd=12'h042.
//  5. DIGITS=2, bin=8'd100 -> ovf=1 with done; bin=8'd99 -> bcd=8'h99, ovf=0.
//  6. BIN2BCD_SEG7_EN defined, bin=8'd5 -> seg[7:0]=8'h92, seg[15:8]=8'hC0;
//     the DIGITS=2 overflow case gives seg=16'hBFBF.

Source files
------------

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one input bit per clock, start/busy/done handshake.
// Optional 7-segment output port `seg` is built when BIN2BCD_SEG7_EN is defined.
module bin2bcd_seq #(
   parameter int BIN_W  = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic [BIN_W-1:0]      bin,
   output logic                  busy,
   output logic                  done,
   output logic [4*DIGITS-1:0]   bcd,
   output logic                  ovf
`ifdef BIN2BCD_SEG7_EN
   ,
   output logic [8*DIGITS-1:0]   seg
`endif
);

   localparam int SW = 4 * DIGITS;
   localparam int CW = $clog2(BIN_W + 1);

   typedef enum logic [1:0] {IDLE, SHIFT, FINISH} state_t;

   state_t           state_q, state_d;
   logic [BIN_W-1:0] shift_q, shift_d;
   logic [SW-1:0]    scratch_q, scratch_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             ovf_acc_q, ovf_acc_d;
   logic [SW-1:0]    bcd_q, bcd_d;
   logic             ovf_q, ovf_d;
   logic             done_q, done_d;
   logic [SW-1:0]    adj;

   // Per-digit add-3 correction; carries never propagate into the next digit.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign adj[4*gi +: 4] = (scratch_q[4*gi +: 4] >= 4'd5) ?
                              scratch_q[4*gi +: 4] + 4'd3 : scratch_q[4*gi +: 4];
   end

   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      scratch_d = scratch_q;
      cnt_d     = cnt_q;
      ovf_acc_d = ovf_acc_q;
      bcd_d     = bcd_q;
      ovf_d     = ovf_q;
      done_d    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               shift_d   = bin;
               scratch_d = '0;
               ovf_acc_d = 1'b0;
               cnt_d     = CW'(BIN_W);
               state_d   = SHIFT;
            end
         end
         SHIFT: begin
            {scratch_d, shift_d} = {adj[SW-2:0], shift_q, 1'b0};
            ovf_acc_d = ovf_acc_q | adj[SW-1];
            cnt_d     = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            bcd_d   = scratch_q;
            ovf_d   = ovf_acc_q;
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         scratch_q <= '0;
         cnt_q     <= '0;
         ovf_acc_q <= 1'b0;
         bcd_q     <= '0;
         ovf_q     <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         scratch_q <= scratch_d;
         cnt_q     <= cnt_d;
         ovf_acc_q <= ovf_acc_d;
         bcd_q     <= bcd_d;
         ovf_q     <= ovf_d;
         done_q    <= done_d;
      end
   end

   assign busy = (state_q == SHIFT);
   assign done = done_q;
   assign bcd  = bcd_q;
   assign ovf  = ovf_q;

`ifdef BIN2BCD_SEG7_EN
   function automatic logic [7:0] seg7(input logic [3:0] d);
      case (d)
         4'd0:    seg7 = 8'hC0;
         4'd1:    seg7 = 8'hF9;
         4'd2:    seg7 = 8'hA4;
         4'd3:    seg7 = 8'hB0;
         4'd4:    seg7 = 8'h99;
         4'd5:    seg7 = 8'h92;
         4'd6:    seg7 = 8'h82;
         4'd7:    seg7 = 8'hF8;
         4'd8:    seg7 = 8'h80;
         4'd9:    seg7 = 8'h90;
         default: seg7 = 8'hFF;
      endcase
   endfunction

   logic [8*DIGITS-1:0] seg_q, seg_d;

   // Decoded from the same scratch/ovf_acc values that load bcd/ovf, so both update together.
   for (genvar gi = 0; gi < DIGITS; gi++) begin : g_seg
      assign seg_d[8*gi +: 8] = (state_q != FINISH) ? seg_q[8*gi +: 8] :
                                ovf_acc_q ? 8'hBF : seg7(scratch_q[4*gi +: 4]);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg_q <= '1;
      end else begin
         seg_q <= seg_d;
      end
   end

   assign seg = seg_q;
`endif

endmodule
